// File: rtl/pll_step_scheduler.sv
// Per-time-step sequencer for the three-phase PLL datapath: issues sta, places the
// read/start strobes at fixed offsets, supervises pll_done and counts completed steps.
module pll_step_scheduler #(
    parameter int CNT_W       = 8,
    parameter int OFS_RD_PI1  = 16,
    parameter int OFS_RD_FIFO = 17,
    parameter int OFS_STA_PI1 = 31,
    parameter int OFS_RD_PI2  = 37,
    parameter int LATENCY     = 128,
    parameter int TIMEOUT     = 200,
    parameter int STEP_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_user,
    input  logic              step_req,
    input  logic              pll_done,
    input  logic              err_clr,
    output logic              sta,
    output logic              rd_pi1,
    output logic              rd_fifo,
    output logic              sta_pi1,
    output logic              rd_pi2,
    output logic              busy,
    output logic              step_done,
    output logic [STEP_W-1:0] step_count,
    output logic              overrun_err,
    output logic              seq_err,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

    localparam logic [CNT_W-1:0] LAST_RUN_C = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    // Strobe offsets packed in output order: rd_pi1, rd_fifo, sta_pi1, rd_pi2.
    localparam logic [4*CNT_W-1:0] OFS_TAB = {CNT_W'(OFS_RD_PI2), CNT_W'(OFS_STA_PI1),
                                              CNT_W'(OFS_RD_FIFO), CNT_W'(OFS_RD_PI1)};

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              accept, complete, timeout_set, overrun_set, seq_set;

    logic              sta_reg, sta_next;
    logic [3:0]        strobe_reg, strobe_next;
    logic              busy_reg, busy_next;
    logic              step_done_reg, step_done_next;
    logic [STEP_W-1:0] step_count_reg, step_count_next;
    logic              overrun_reg, overrun_next;
    logic              seq_reg, seq_next;
    logic              timeout_reg, timeout_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            sta_reg        <= 1'b0;
            strobe_reg     <= '0;
            busy_reg       <= 1'b0;
            step_done_reg  <= 1'b0;
            step_count_reg <= '0;
            overrun_reg    <= 1'b0;
            seq_reg        <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            sta_reg        <= sta_next;
            strobe_reg     <= strobe_next;
            busy_reg       <= busy_next;
            step_done_reg  <= step_done_next;
            step_count_reg <= step_count_next;
            overrun_reg    <= overrun_next;
            seq_reg        <= seq_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        accept      = 1'b0;
        complete    = 1'b0;
        timeout_set = 1'b0;
        overrun_set = 1'b0;
        seq_set     = 1'b0;
        if (rst_user) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    seq_set = pll_done;
                    if (step_req) begin
                        accept     = 1'b1;
                        state_next = RUN;
                        cnt_next   = '0;
                    end
                end
                RUN: begin
                    seq_set     = pll_done;
                    overrun_set = step_req;
                    cnt_next    = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_RUN_C)
                        state_next = WAIT;
                end
                WAIT: begin
                    if (pll_done) begin
                        // A request coinciding with completion chains straight into the next step.
                        complete   = 1'b1;
                        accept     = step_req;
                        state_next = step_req ? RUN : IDLE;
                        cnt_next   = '0;
                    end else begin
                        overrun_set = step_req;
                        if (cnt_reg == TIMEOUT_C) begin
                            timeout_set = 1'b1;
                            state_next  = IDLE;
                            cnt_next    = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        sta_next        = accept;
        step_done_next  = complete;
        busy_next       = (state_next != IDLE);
        step_count_next = step_count_reg;
        if (complete)
            step_count_next = step_count_reg + STEP_W'(1);
        overrun_next = overrun_set | (overrun_reg & ~err_clr);
        seq_next     = seq_set | (seq_reg & ~err_clr);
        timeout_next = timeout_set | (timeout_reg & ~err_clr);
        if (rst_user) begin
            step_count_next = '0;
            overrun_next    = 1'b0;
            seq_next        = 1'b0;
            timeout_next    = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_strobe
            assign strobe_next[gi] = (state_next == RUN) &&
                                     (cnt_next == OFS_TAB[gi*CNT_W +: CNT_W]);
        end
    endgenerate

    assign sta         = sta_reg;
    assign rd_pi1      = strobe_reg[0];
    assign rd_fifo     = strobe_reg[1];
    assign sta_pi1     = strobe_reg[2];
    assign rd_pi2      = strobe_reg[3];
    assign busy        = busy_reg;
    assign step_done   = step_done_reg;
    assign step_count  = step_count_reg;
    assign overrun_err = overrun_reg;
    assign seq_err     = seq_reg;
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_pll_step_scheduler.sv
// Bench for pll_step_scheduler: directed scenarios then random traffic, every cycle
// compared against an elapsed-time reference model of one PLL step.
module tb_pll_step_scheduler;

    localparam int LAT = 128;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_user = 1'b0;
    logic        step_req = 1'b0;
    logic        pll_done = 1'b0;
    logic        err_clr = 1'b0;
    logic        sta, rd_pi1, rd_fifo, sta_pi1, rd_pi2, busy, step_done;
    logic [15:0] step_count;
    logic        overrun_err, seq_err, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    pll_step_scheduler dut (
        .clk(clk), .rst(rst), .rst_user(rst_user), .step_req(step_req),
        .pll_done(pll_done), .err_clr(err_clr), .sta(sta), .rd_pi1(rd_pi1),
        .rd_fifo(rd_fifo), .sta_pi1(sta_pi1), .rd_pi2(rd_pi2), .busy(busy),
        .step_done(step_done), .step_count(step_count), .overrun_err(overrun_err),
        .seq_err(seq_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: a step is "active" from its sta cycle, m_t counts cycles since sta.
    int          ofs [4] = '{16, 17, 31, 37};
    bit          m_act;
    int          m_t;
    logic [15:0] m_cnt;
    bit          m_ovr, m_seq, m_to;
    bit          e_sta, e_done, e_busy;
    bit   [3:0]  e_strb;

    task automatic model_clear();
        m_act = 0; m_t = 0; m_cnt = '0;
        m_ovr = 0; m_seq = 0; m_to = 0;
        e_sta = 0; e_done = 0; e_busy = 0; e_strb = '0;
    endtask

    task automatic model_edge(input bit req, input bit done, input bit clr, input bit ur);
        bit in_wait, ok, tmo, start;
        if (ur) begin
            model_clear();
            return;
        end
        in_wait = m_act && (m_t >= LAT);
        ok      = in_wait && done;
        tmo     = in_wait && !done && (m_t == TMO);
        start   = req && (!m_act || ok);
        m_ovr   = (req && m_act && !ok) || (m_ovr && !clr);
        m_seq   = (done && !in_wait) || (m_seq && !clr);
        m_to    = tmo || (m_to && !clr);
        if (ok) m_cnt = m_cnt + 16'd1;
        e_done  = ok;
        e_sta   = start;
        if (start) begin
            m_act = 1; m_t = 0;
        end else if (m_act && !ok && !tmo) begin
            m_t = m_t + 1;
        end else begin
            m_act = 0; m_t = 0;
        end
        e_busy = m_act;
        for (int i = 0; i < 4; i++) e_strb[i] = m_act && (m_t == ofs[i]);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        chk("sta",         32'(sta),         32'(e_sta));
        chk("rd_pi1",      32'(rd_pi1),      32'(e_strb[0]));
        chk("rd_fifo",     32'(rd_fifo),     32'(e_strb[1]));
        chk("sta_pi1",     32'(sta_pi1),     32'(e_strb[2]));
        chk("rd_pi2",      32'(rd_pi2),      32'(e_strb[3]));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("step_done",   32'(step_done),   32'(e_done));
        chk("step_count",  32'(step_count),  32'(m_cnt));
        chk("overrun_err", 32'(overrun_err), 32'(m_ovr));
        chk("seq_err",     32'(seq_err),     32'(m_seq));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
    endtask

    task automatic cycle(input bit req, input bit done, input bit clr, input bit ur);
        step_req = req; pll_done = done; err_clr = clr; rst_user = ur;
        @(posedge clk);
        cyc++;
        model_edge(req, done, clr, ur);
        #1;
        check_all();
        if (e_done) $display("step %0d completed at cycle %0d", m_cnt, cyc);
        step_req = 0; pll_done = 0; err_clr = 0; rst_user = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_clear();
        check_all();
        $display("async reset asserted at cycle %0d", cyc);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Nominal step: request at edge 0, done at edge 129.
        cycle(1, 0, 0, 0);
        idle(128);
        cycle(0, 1, 0, 0);
        chk("nom_count", 32'(step_count), 32'd1);
        chk("nom_busy",  32'(busy),       32'd0);
        idle(1);
        $display("nominal step sequence issued");

        // Overrun at sta+50, then clear.
        cycle(1, 0, 0, 0);
        idle(50);
        cycle(1, 0, 0, 0);
        chk("ovr_set", 32'(overrun_err), 32'd1);
        idle(77);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        chk("ovr_clr", 32'(overrun_err), 32'd0);
        $display("overrun sequence issued");

        // Back-to-back completion and new request.
        cycle(1, 0, 0, 0);
        idle(128);
        cycle(1, 1, 0, 0);
        chk("b2b_sta",  32'(sta),       32'd1);
        chk("b2b_done", 32'(step_done), 32'd1);
        idle(150);
        cycle(0, 1, 0, 0);
        idle(2);
        $display("back-to-back sequence issued");

        // Timeout, then a fresh request is accepted.
        cycle(1, 0, 0, 0);
        idle(201);
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        idle(2);
        cycle(1, 0, 0, 0);
        idle(128);
        cycle(0, 1, 0, 0);
        $display("timeout sequence issued");

        // Early done then the real one; also a set-vs-clear collision.
        cycle(1, 0, 0, 0);
        idle(60);
        cycle(0, 1, 0, 0);
        chk("early_seq", 32'(seq_err), 32'd1);
        idle(67);
        cycle(0, 1, 1, 0);
        idle(1);
        cycle(0, 1, 1, 0);
        idle(1);
        $display("early-done sequence issued");

        // Asynchronous reset mid-step, then synchronous user reset mid-step.
        cycle(1, 0, 0, 0);
        idle(20);
        async_reset();
        idle(40);
        cycle(1, 0, 0, 0);
        idle(20);
        cycle(1, 0, 0, 1);
        idle(40);
        $display("mid-step reset sequence issued");

        // Random traffic.
        for (int i = 0; i < 5000; i++) begin
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 999) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
